// File: rtl/fb_arbiter_pkg.sv
// Shared owner encoding and lock state for the frame-buffer/CPU memory arbiter.
// Pure definitions: no latency, no backpressure.
package fb_arbiter_pkg;
   localparam logic OWNER_VIDEO = 1'b0;
   localparam logic OWNER_CPU   = 1'b1;

   typedef enum logic {
      ST_UNLOCKED = 1'b0,
      ST_LOCKED   = 1'b1
   } lock_t;
endpackage

// File: rtl/tag_fifo.sv
// Small synchronous FIFO holding the issuer tag of each outstanding read.
// One-cycle write-to-read latency; push is dropped when full, pop ignored when empty.
module tag_fifo #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign full   = (r_count == (AW+1)'(DEPTH));
   assign empty  = (r_count == '0);
   assign count  = r_count;
   assign dout   = r_mem[r_rptr];
   assign w_push = push & ~full;
   assign w_pop  = pop & ~empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= din;
   end
endmodule

// File: rtl/fb_arbiter.sv
// Video-priority arbiter merging frame-buffer reads and CPU accesses onto one pipelined slave.
// Zero added latency on requests and responses; a stalled grant is locked until the slave accepts it.
module fb_arbiter
   import fb_arbiter_pkg::*;
#(
   parameter int ADDR_W         = 30,
   parameter int DATA_W         = 32,
   parameter int MAX_PENDING    = 8,
   parameter int CPU_STARVE_MAX = 16
) (
   input  logic                memory_clock,
   input  logic                reset_n,
   input  logic [ADDR_W-1:0]   vid_address,
   input  logic                vid_read,
   output logic                vid_waitrequest,
   output logic [DATA_W-1:0]   vid_readdata,
   output logic                vid_readdatavalid,
   input  logic [ADDR_W-1:0]   cpu_address,
   input  logic                cpu_read,
   input  logic                cpu_write,
   input  logic [DATA_W-1:0]   cpu_writedata,
   input  logic [DATA_W/8-1:0] cpu_byteenable,
   output logic                cpu_waitrequest,
   output logic [DATA_W-1:0]   cpu_readdata,
   output logic                cpu_readdatavalid,
   output logic [ADDR_W-1:0]   mem_address,
   output logic                mem_read,
   output logic                mem_write,
   output logic [DATA_W-1:0]   mem_writedata,
   output logic [DATA_W/8-1:0] mem_byteenable,
   input  logic                mem_waitrequest,
   input  logic [DATA_W-1:0]   mem_readdata,
   input  logic                mem_readdatavalid,
   output logic                err_orphan
);
   localparam int SW = $clog2(CPU_STARVE_MAX) + 1;
   localparam int CW = $clog2(MAX_PENDING) + 1;

   lock_t         r_lock;
   lock_t         w_lock_nxt;
   logic          r_owner;
   logic          w_owner_nxt;
   logic [SW-1:0] r_starve;
   logic          r_err_orphan;

   logic          w_full;
   logic          w_empty;
   logic [CW-1:0] w_count;
   logic          w_head;
   logic          w_room;
   logic          w_vid_elig;
   logic          w_cpu_elig;
   logic          w_cpu_req;
   logic          w_win_vid;
   logic          w_win_cpu;
   logic          w_issue;
   logic          w_accept;
   logic          w_push;
   logic          w_pop;

   assign w_room     = (w_count < CW'(MAX_PENDING));
   assign w_cpu_req  = cpu_read | cpu_write;
   assign w_vid_elig = vid_read & w_room;
   assign w_cpu_elig = cpu_write | (cpu_read & w_room);

   always_comb begin
      w_win_vid   = 1'b0;
      w_win_cpu   = 1'b0;
      w_lock_nxt  = r_lock;
      w_owner_nxt = r_owner;
      if (r_lock == ST_LOCKED) begin
         w_win_cpu = (r_owner == OWNER_CPU);
         w_win_vid = (r_owner == OWNER_VIDEO);
      end else if ((r_starve == SW'(CPU_STARVE_MAX)) && w_cpu_elig) begin
         w_win_cpu = 1'b1;
      end else if (w_vid_elig) begin
         w_win_vid = 1'b1;
      end else if (w_cpu_elig) begin
         w_win_cpu = 1'b1;
      end
      // A stalled request pins the grant; anything else (accept or idle) reopens arbitration.
      if (w_issue && mem_waitrequest) begin
         w_lock_nxt  = ST_LOCKED;
         w_owner_nxt = w_win_cpu ? OWNER_CPU : OWNER_VIDEO;
      end else begin
         w_lock_nxt  = ST_UNLOCKED;
      end
   end

   assign mem_read        = (w_win_vid & vid_read) | (w_win_cpu & cpu_read & ~cpu_write);
   assign mem_write       = w_win_cpu & cpu_write;
   assign mem_address     = w_win_cpu ? cpu_address : vid_address;
   assign mem_writedata   = cpu_writedata;
   assign mem_byteenable  = cpu_byteenable;
   assign vid_waitrequest = w_win_vid ? mem_waitrequest : 1'b1;
   assign cpu_waitrequest = w_win_cpu ? mem_waitrequest : 1'b1;

   assign w_issue  = mem_read | mem_write;
   assign w_accept = w_issue & ~mem_waitrequest;
   assign w_push   = w_accept & mem_read & ~w_full;
   assign w_pop    = mem_readdatavalid & ~w_empty;

   assign vid_readdatavalid = w_pop & (w_head == OWNER_VIDEO);
   assign cpu_readdatavalid = w_pop & (w_head == OWNER_CPU);
   assign vid_readdata      = mem_readdata;
   assign cpu_readdata      = mem_readdata;
   assign err_orphan        = r_err_orphan;

   tag_fifo #(
      .WIDTH (1),
      .DEPTH (MAX_PENDING)
   ) u_tag_fifo (
      .clk   (memory_clock),
      .rst_n (reset_n),
      .push  (w_push),
      .pop   (w_pop),
      .din   (w_win_cpu),
      .dout  (w_head),
      .full  (w_full),
      .empty (w_empty),
      .count (w_count)
   );

   always_ff @(posedge memory_clock or negedge reset_n) begin
      if (!reset_n) begin
         r_lock       <= ST_UNLOCKED;
         r_owner      <= OWNER_VIDEO;
         r_starve     <= '0;
         r_err_orphan <= 1'b0;
      end else begin
         r_lock  <= w_lock_nxt;
         r_owner <= w_owner_nxt;
         if (w_cpu_req && w_win_vid) begin
            if (r_starve != SW'(CPU_STARVE_MAX)) r_starve <= r_starve + 1'b1;
         end else if (w_accept && w_win_cpu) begin
            r_starve <= '0;
         end
         if (mem_readdatavalid && w_empty) r_err_orphan <= 1'b1;
      end
   end
endmodule

// File: tb/tb_fb_arbiter.sv
// Randomized bench for fb_arbiter: holding Avalon masters, an in-order variable-latency
// slave, and a queue-based reference model of arbitration and response routing.
module tb_fb_arbiter;
   localparam int AW   = 30;
   localparam int DW   = 32;
   localparam int MAXP = 8;
   localparam int SMAX = 16;

   logic            memory_clock = 1'b0;
   logic            reset_n;
   logic [AW-1:0]   vid_address;
   logic            vid_read;
   logic            vid_waitrequest;
   logic [DW-1:0]   vid_readdata;
   logic            vid_readdatavalid;
   logic [AW-1:0]   cpu_address;
   logic            cpu_read;
   logic            cpu_write;
   logic [DW-1:0]   cpu_writedata;
   logic [DW/8-1:0] cpu_byteenable;
   logic            cpu_waitrequest;
   logic [DW-1:0]   cpu_readdata;
   logic            cpu_readdatavalid;
   logic [AW-1:0]   mem_address;
   logic            mem_read;
   logic            mem_write;
   logic [DW-1:0]   mem_writedata;
   logic [DW/8-1:0] mem_byteenable;
   logic            mem_waitrequest;
   logic [DW-1:0]   mem_readdata;
   logic            mem_readdatavalid;
   logic            err_orphan;

   always #5 memory_clock = ~memory_clock;

   fb_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .MAX_PENDING(MAXP), .CPU_STARVE_MAX(SMAX)
   ) dut (
      .memory_clock(memory_clock), .reset_n(reset_n),
      .vid_address(vid_address), .vid_read(vid_read),
      .vid_waitrequest(vid_waitrequest), .vid_readdata(vid_readdata),
      .vid_readdatavalid(vid_readdatavalid),
      .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
      .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
      .cpu_waitrequest(cpu_waitrequest), .cpu_readdata(cpu_readdata),
      .cpu_readdatavalid(cpu_readdatavalid),
      .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
      .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
      .mem_readdatavalid(mem_readdatavalid), .err_orphan(err_orphan)
   );

   typedef struct {
      int          due;
      logic [31:0] data;
   } resp_t;

   int    total = 0;
   int    bad   = 0;
   int    cyc   = 0;
   // reference model: issuer tags of outstanding reads (1 = CPU), held grant, starvation count
   bit    mq[$];
   int    held = -1;
   int    starve = 0;
   bit    merr = 1'b0;
   resp_t sq[$];
   int    p_vid, p_cpu, p_wait, lat_lo, lat_hi;
   bit    vid_hold = 1'b0, cpu_hold = 1'b0;
   bit    cpu_oneshot = 1'b0, inject_orphan = 1'b0;
   int    cpu_wait = 0, last_cpu_wait = -1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive();
      if (!vid_hold) begin
         vid_read    = ($urandom_range(99) < p_vid);
         vid_address = AW'($urandom);
      end
      if (!cpu_hold) begin
         cpu_read  = 1'b0;
         cpu_write = 1'b0;
         if (cpu_oneshot) begin
            cpu_read    = 1'b1;
            cpu_oneshot = 1'b0;
         end else if ($urandom_range(99) < p_cpu) begin
            if ($urandom_range(1) == 1) cpu_read = 1'b1;
            else                        cpu_write = 1'b1;
         end
         cpu_address    = AW'($urandom);
         cpu_writedata  = $urandom;
         cpu_byteenable = 4'($urandom);
      end
      mem_waitrequest   = ($urandom_range(99) < p_wait);
      mem_readdatavalid = 1'b0;
      mem_readdata      = $urandom;
      if (inject_orphan) begin
         mem_readdatavalid = 1'b1;
         inject_orphan     = 1'b0;
      end else if (sq.size() > 0 && sq[0].due <= cyc) begin
         mem_readdatavalid = 1'b1;
         mem_readdata      = sq[0].data;
         void'(sq.pop_front());
      end
   endtask

   task automatic check_and_update();
      bit full, v_ok, c_ok, creq, e_rd, e_wr, pop, acc;
      int win;
      full = (mq.size() >= MAXP);
      creq = cpu_read || cpu_write;
      v_ok = vid_read && !full;
      c_ok = cpu_write || (cpu_read && !full);
      if (held >= 0)                   win = held;
      else if (starve == SMAX && c_ok) win = 1;
      else if (v_ok)                   win = 0;
      else if (c_ok)                   win = 1;
      else                             win = -1;
      e_rd = (win == 0) ? vid_read : (win == 1) ? (cpu_read && !cpu_write) : 1'b0;
      e_wr = (win == 1) && cpu_write;
      pop  = mem_readdatavalid && (mq.size() > 0);

      check_eq("mem_read", mem_read, e_rd);
      check_eq("mem_write", mem_write, e_wr);
      if (e_rd || e_wr)
         check_eq("mem_address", mem_address, (win == 1) ? cpu_address : vid_address);
      if (e_wr) begin
         check_eq("mem_writedata", mem_writedata, cpu_writedata);
         check_eq("mem_byteenable", mem_byteenable, cpu_byteenable);
      end
      check_eq("vid_waitrequest", vid_waitrequest, (win == 0) ? mem_waitrequest : 1'b1);
      check_eq("cpu_waitrequest", cpu_waitrequest, (win == 1) ? mem_waitrequest : 1'b1);
      check_eq("vid_readdatavalid", vid_readdatavalid, pop && !mq[0]);
      check_eq("cpu_readdatavalid", cpu_readdatavalid, pop && mq[0]);
      if (pop && !mq[0]) check_eq("vid_readdata", vid_readdata, mem_readdata);
      if (pop && mq[0])  check_eq("cpu_readdata", cpu_readdata, mem_readdata);
      check_eq("err_orphan", err_orphan, merr);

      acc  = (e_rd || e_wr) && !mem_waitrequest;
      held = ((e_rd || e_wr) && mem_waitrequest) ? win : -1;
      if (mem_readdatavalid && mq.size() == 0) merr = 1'b1;
      if (pop) void'(mq.pop_front());
      if (acc && e_rd) begin
         mq.push_back(win == 1);
         sq.push_back('{due: cyc + $urandom_range(lat_hi, lat_lo), data: $urandom});
      end
      if (creq && win == 0)          starve = (starve < SMAX) ? starve + 1 : SMAX;
      else if (acc && win == 1)      starve = 0;
      if (creq && !(acc && win == 1)) cpu_wait++;
      if (acc && win == 1) begin
         last_cpu_wait = cpu_wait;
         cpu_wait      = 0;
      end
      vid_hold = vid_read && !(acc && win == 0);
      cpu_hold = creq && !(acc && win == 1);
   endtask

   task automatic run(input int n, input int pv, input int pc, input int pw,
                      input int llo, input int lhi);
      p_vid = pv; p_cpu = pc; p_wait = pw; lat_lo = llo; lat_hi = lhi;
      for (int i = 0; i < n; i++) begin
         drive();
         #4;
         check_and_update();
         @(posedge memory_clock);
         #1;
         cyc++;
      end
   endtask

   task automatic do_reset();
      reset_n           = 1'b0;
      vid_read          = 1'b0;
      cpu_read          = 1'b0;
      cpu_write         = 1'b0;
      mem_readdatavalid = 1'b0;
      mem_waitrequest   = 1'b0;
      vid_address       = '0;
      cpu_address       = '0;
      cpu_writedata     = '0;
      cpu_byteenable    = '0;
      mem_readdata      = '0;
      #2;
      check_eq("rst_vid_waitrequest", vid_waitrequest, 1'b1);
      check_eq("rst_cpu_waitrequest", cpu_waitrequest, 1'b1);
      check_eq("rst_vid_readdatavalid", vid_readdatavalid, 1'b0);
      check_eq("rst_cpu_readdatavalid", cpu_readdatavalid, 1'b0);
      check_eq("rst_err_orphan", err_orphan, 1'b0);
      check_eq("rst_mem_read", mem_read, 1'b0);
      check_eq("rst_mem_write", mem_write, 1'b0);
      repeat (2) begin
         @(posedge memory_clock);
         cyc++;
      end
      #1;
      reset_n  = 1'b1;
      mq.delete();
      held     = -1;
      starve   = 0;
      merr     = 1'b0;
      vid_hold = 1'b0;
      cpu_hold = 1'b0;
      cpu_wait = 0;
   endtask

   initial begin
      do_reset();
      // video streams alone, then one CPU read must lose exactly SMAX times before being forced through
      run(3, 100, 0, 0, 3, 3);
      cpu_oneshot = 1'b1;
      run(30, 100, 0, 0, 3, 3);
      check_eq("cpu_starve_wait", last_cpu_wait, SMAX);
      run(20, 0, 0, 0, 3, 3);
      run(600, 60, 50, 25, 2, 7);
      // long slave latency keeps the tag FIFO at its limit
      run(200, 90, 60, 10, 10, 14);
      run(300, 80, 70, 70, 2, 7);
      run(60, 0, 0, 0, 2, 7);
      check_eq("drained_before_orphan", mq.size() + sq.size(), 0);
      inject_orphan = 1'b1;
      run(4, 0, 0, 0, 2, 7);
      check_eq("err_orphan_sticky", err_orphan, 1'b1);
      run(100, 70, 60, 20, 4, 7);
      do_reset();
      run(60, 50, 50, 20, 2, 7);
      run(60, 0, 0, 0, 2, 7);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Two-master Avalon-style arbiter in the memory clock domain. It merges the video frame-buffer read master (`fb_*` of `video`) and the CPU data master onto one pipelined memory slave port. Video has priority; a starvation guard bounds CPU latency. An in-order tag FIFO routes read responses back to the master that issued each read.

## Interface
Parameters:
- `ADDR_W`, 30, word address width (matches `fb_address`)
- `DATA_W`, 32, data width
- `MAX_PENDING`, 8, outstanding reads tracked; power of two, ≥2
- `CPU_STARVE_MAX`, 16, cycles a pending CPU request may lose to video before it is forced through

Ports (all synchronous to `memory_clock`):
- `memory_clock` in 1: sole clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `vid_address` in ADDR_W; `vid_read` in 1: video read request.
- `vid_waitrequest` out 1; `vid_readdata` out DATA_W; `vid_readdatavalid` out 1.
- `cpu_address` in ADDR_W; `cpu_read` in 1; `cpu_write` in 1.
- `cpu_writedata` in DATA_W; `cpu_byteenable` in DATA_W/8.
- `cpu_waitrequest` out 1; `cpu_readdata` out DATA_W; `cpu_readdatavalid` out 1.
- `mem_address` out ADDR_W; `mem_read` out 1; `mem_write` out 1.
- `mem_writedata` out DATA_W; `mem_byteenable` out DATA_W/8.
- `mem_waitrequest` in 1; `mem_readdata` in DATA_W; `mem_readdatavalid` in 1. The slave returns read data in issue order with variable latency.
- `err_orphan` out 1: sticky; set by `mem_readdatavalid` while the tag FIFO is empty.

## Operation
- Registered state:
  - `lock` (0/1) and `owner` (0 = video, 1 = CPU).
  - Tag FIFO of `MAX_PENDING` one-bit entries plus an occupancy count `0..MAX_PENDING`.
  - Starvation counter `starve`, width clog2(`CPU_STARVE_MAX`)+1.
  - `err_orphan`.
- Eligibility:
  - A video request is eligible when `vid_read` is high and count < `MAX_PENDING`.
  - A CPU read is eligible when count < `MAX_PENDING`.
  - A CPU write is always eligible.
  - `cpu_read` and `cpu_write` are never both high; if they are, the write wins.
- States:
  - UNLOCKED (`lock`=0) — winner selected combinationally each cycle:
    - If `starve` == `CPU_STARVE_MAX` and CPU is eligible: CPU.
    - Else if video is eligible: video.
    - Else if CPU is eligible: CPU.
    - Else: none.
  - LOCKED (`lock`=1) — winner = `owner`, unconditionally.
- The winner's signals drive `mem_*` combinationally. With no winner, `mem_read`=`mem_write`=0.
- `waitrequest` back to the masters:
  - The winner's `waitrequest` = `mem_waitrequest`.
  - The loser's `waitrequest` = 1.
  - With no winner, both = 1.
- Transitions:
  - Request issued and `mem_waitrequest`=1: LOCKED, `owner` = winner. This holds `mem_*` stable, as Avalon requires.
  - Request accepted (`mem_waitrequest`=0): UNLOCKED.
- On an accepted read, push `owner` into the tag FIFO.
- On `mem_readdatavalid` with count > 0:
  - Pop the head entry.
  - Assert `vid_readdatavalid` if the head is 0, else `cpu_readdatavalid`. Never both.
  - `mem_readdata` is broadcast to both `*_readdata`.
- Simultaneous push and pop: count unchanged.
- Full FIFO: a push is blocked at count == `MAX_PENDING` even if a pop occurs in the same cycle.
- `starve`:
  - Increments (saturating at `CPU_STARVE_MAX`) each cycle CPU requests and video wins.
  - Clears when a CPU request is accepted.
  - Unchanged otherwise.
- Reset mid-operation clears all state. Responses still in flight from the slave then raise `err_orphan`; that is accepted behaviour.

## Timing
- Reset values:
  - `lock`=0, count=0, `starve`=0, `err_orphan`=0.
  - All `*_readdatavalid`=0.
  - `vid_waitrequest`=`cpu_waitrequest`=1 while `vid_read`/`cpu_read`/`cpu_write` are low.
- Request path has zero added latency: acceptance happens in the same cycle that `mem_waitrequest`=0.
- Response path has zero added latency: `*_readdatavalid` is combinational from `mem_readdatavalid` and the FIFO head.
- A FIFO update becomes visible to eligibility on the next cycle.
- `err_orphan` rises the cycle after the offending beat.

## Structure
- Shared package `fb_arbiter_pkg`: owner encoding constants `OWNER_VIDEO`=0 and `OWNER_CPU`=1.
- Sub-module `tag_fifo`: synchronous, single clock, async active-low reset.
  - Parameters: width, depth.
  - Ports: push, pop, din, dout, full, empty, count.

## Test plan
- Video streams `vid_read` continuously, slave has 3-cycle latency and `mem_waitrequest`=0 → one accept per cycle, 8 outstanding max, `vid_readdatavalid` beats = requests, in order.
- Video and CPU request in the same cycle, count=0 → video wins; CPU `waitrequest`=1; `starve` increments.
- Video saturates and CPU holds a read for 20 cycles → CPU is granted on the cycle `starve` reaches 16 and accepted that cycle; `starve` returns to 0.
- Slave holds `mem_waitrequest`=1 for 5 cycles on a CPU write while video asserts `vid_read` → `mem_*` stays stable with CPU write data; video is granted the cycle after acceptance.
- Interleaved video/CPU reads, responses 2–7 cycles later → each beat is routed to its issuer; count never exceeds 8; a 9th read waits until a pop.
- `mem_readdatavalid` pulse with count=0 → neither `*_readdatavalid` asserts; `err_orphan`=1 until reset.
